// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge
//   Converts a simple valid/ready memory request stream into single-beat AXI
//   transactions and returns the responses in request-issue order.
//
//   Parameters
//     ADDR_WIDTH  byte address width of request and AXI address ports
//     DATA_WIDTH  data width (32 or 64)
//     ID_WIDTH    AXI ID width
//     WR_ID/RD_ID constant AWID / ARID values
//     MAX_OUT     max outstanding transactions (power of two, 2..16)
//
//   Ports
//     clk, rst             rising-edge clock, synchronous active-high reset
//     req_*                request channel (valid/ready, wr, addr, wdata, wstrb)
//     resp_*               response channel (valid/ready, rdata, wr, err)
//     axi_aw*/w*/b*/ar*/r* AXI master channels
module mem_axi_bridge #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int WR_ID      = 0,
    parameter int RD_ID      = 1,
    parameter int MAX_OUT    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    // request
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_wr,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    // response
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      resp_wr,
    output logic                      resp_err,
    // AXI write address
    output logic [ID_WIDTH-1:0]       axi_awid,
    output logic [ADDR_WIDTH-1:0]     axi_awaddr,
    output logic [7:0]                axi_awlen,
    output logic [2:0]                axi_awsize,
    output logic [1:0]                axi_awburst,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    // AXI write data
    output logic [DATA_WIDTH-1:0]     axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                      axi_wlast,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    // AXI write response
    input  logic [ID_WIDTH-1:0]       axi_bid,
    input  logic [1:0]                axi_bresp,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    // AXI read address
    output logic [ID_WIDTH-1:0]       axi_arid,
    output logic [ADDR_WIDTH-1:0]     axi_araddr,
    output logic [7:0]                axi_arlen,
    output logic [2:0]                axi_arsize,
    output logic [1:0]                axi_arburst,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    // AXI read data
    input  logic [ID_WIDTH-1:0]       axi_rid,
    input  logic [DATA_WIDTH-1:0]     axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rlast,
    input  logic                      axi_rvalid,
    output logic                      axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(MAX_OUT);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                   aw_pend_q, aw_pend_d;
    logic                   w_pend_q,  w_pend_d;
    logic                   ar_pend_q, ar_pend_d;
    // One address register serves AW and AR: a new request is only taken
    // when no address channel is pending, so they never overlap.
    logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]      wstrb_q, wstrb_d;
    logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    // Order FIFO: 1 = write, 0 = read. Its occupancy equals out_cnt, since
    // both change on request accept and on response load.
    logic [MAX_OUT-1:0]     fifo_q, fifo_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]  resp_rdata_q, resp_rdata_d;
    logic                   resp_wr_q, resp_wr_d;
    logic                   resp_err_q, resp_err_d;

    // ------------------------------------------------------------------
    // Handshake / control terms
    // ------------------------------------------------------------------
    logic resp_free, fifo_empty, head_wr;
    logic req_acc, aw_hs, w_hs, ar_hs, b_hs, r_hs, resp_load;

    assign resp_free  = !resp_valid_q || resp_ready;
    assign fifo_empty = (out_cnt_q == '0);
    assign head_wr    = fifo_q[rd_ptr_q];

    // rst gating keeps every handshake output low during the reset cycle
    // itself, before the registered state has been cleared.
    assign req_ready  = !rst && !aw_pend_q && !w_pend_q && !ar_pend_q
                        && (out_cnt_q < CNT_W'(MAX_OUT));
    assign axi_bready = !rst && !fifo_empty &&  head_wr && resp_free;
    assign axi_rready = !rst && !fifo_empty && !head_wr && resp_free;

    assign req_acc   = req_valid && req_ready;
    assign aw_hs     = axi_awvalid && axi_awready;
    assign w_hs      = axi_wvalid  && axi_wready;
    assign ar_hs     = axi_arvalid && axi_arready;
    assign b_hs      = axi_bvalid  && axi_bready;
    assign r_hs      = axi_rvalid  && axi_rready;
    assign resp_load = b_hs || r_hs;  // mutually exclusive by head_wr

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        aw_pend_d    = aw_pend_q;
        w_pend_d     = w_pend_q;
        ar_pend_d    = ar_pend_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        out_cnt_d    = out_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_d       = fifo_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_wr_d    = resp_wr_q;
        resp_err_d   = resp_err_q;

        // AW and W retire independently, in either order
        if (aw_hs) aw_pend_d = 1'b0;
        if (w_hs)  w_pend_d  = 1'b0;
        if (ar_hs) ar_pend_d = 1'b0;

        if (req_acc) begin
            addr_d           = req_addr;
            fifo_d[wr_ptr_q] = req_wr;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            if (req_wr) begin
                wdata_d  = req_wdata;
                wstrb_d  = req_wstrb;
                aw_pend_d = 1'b1;
                w_pend_d  = 1'b1;
            end else begin
                ar_pend_d = 1'b1;
            end
        end

        // Response register: a load may coincide with consumption of the
        // previous response, giving back-to-back responses.
        if (resp_load) begin
            resp_valid_d = 1'b1;
            resp_wr_d    = b_hs;
            resp_rdata_d = b_hs ? '0 : axi_rdata;
            resp_err_d   = b_hs ? axi_bresp[1] : axi_rresp[1];
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end

        case ({req_acc, resp_load})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_pend_q    <= 1'b0;
            w_pend_q     <= 1'b0;
            ar_pend_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            out_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_wr_q    <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            aw_pend_q    <= aw_pend_d;
            w_pend_q     <= w_pend_d;
            ar_pend_q    <= ar_pend_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            out_cnt_q    <= out_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_q       <= fifo_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_wr_q    <= resp_wr_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_wr     = resp_wr_q;
    assign resp_err    = resp_err_q;

    assign axi_awid    = ID_WIDTH'(WR_ID);
    assign axi_awaddr  = addr_q;
    assign axi_awlen   = 8'd0;
    assign axi_awsize  = AXI_SIZE;
    assign axi_awburst = 2'b01;
    assign axi_awvalid = aw_pend_q;

    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wlast   = 1'b1;
    assign axi_wvalid  = w_pend_q;

    assign axi_arid    = ID_WIDTH'(RD_ID);
    assign axi_araddr  = addr_q;
    assign axi_arlen   = 8'd0;
    assign axi_arsize  = AXI_SIZE;
    assign axi_arburst = 2'b01;
    assign axi_arvalid = ar_pend_q;

    // IDs, RLAST and the low RESP bits carry no information for
    // in-order single-beat traffic.
    logic unused_inputs;
    assign unused_inputs = ^{axi_bid, axi_rid, axi_rlast, axi_bresp[0], axi_rresp[0]};

endmodule
